// File: rtl/ifetch_align.sv
// Instruction fetch aligner: streams imem words through a 6-halfword queue and
// emits naturally aligned 16/32-bit RISC-V instructions with their byte PCs.
module ifetch_align #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_dout,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH+1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH+1:0] instr_pc,
  output logic                  instr_is_rvc
);

  localparam int unsigned PCW = ADDR_WIDTH + 2;
  localparam int unsigned QD  = 6;
  localparam logic [PCW-1:0] RST_PC = PCW'(RESET_PC);

  logic [QD-1:0][15:0]   q, q_sh, q_nxt;
  logic [2:0]            cnt, cnt_nxt, base;
  logic [3:0]            cnt_sum;
  logic [ADDR_WIDTH-1:0] fwa, fwa_nxt;
  logic [PCW-1:0]        pc, pc_nxt;
  logic                  inflight, inflight_nxt;
  logic                  drop_low, drop_low_nxt;
  logic                  h0_rvc, issue, xfer;
  logic [1:0]            n_push, n_pop;
  logic                  unused_bits;

  assign unused_bits = redirect_pc[0];

  // Decode-side view of the queue head
  assign h0_rvc       = q[0][1:0] != 2'b11;
  assign instr_valid  = !redirect_valid && ((cnt >= 3'd2) || (cnt == 3'd1 && h0_rvc));
  assign instr        = h0_rvc ? {16'h0000, q[0]} : {q[1], q[0]};
  assign instr_is_rvc = h0_rvc;
  assign instr_pc     = pc;
  assign imem_addr    = fwa;
  assign xfer         = instr_valid && instr_ready;

  // Next-state: issue, push, pop, with redirect overriding everything
  always_comb begin
    issue        = 1'b0;
    n_push       = 2'd0;
    n_pop        = 2'd0;
    cnt_sum      = 4'(cnt);
    base         = cnt;
    q_sh         = q;
    q_nxt        = q;
    cnt_nxt      = cnt;
    fwa_nxt      = fwa;
    pc_nxt       = pc;
    inflight_nxt = 1'b0;
    drop_low_nxt = drop_low;

    if (redirect_valid) begin
      cnt_nxt      = 3'd0;
      fwa_nxt      = redirect_pc[PCW-1:2];
      pc_nxt       = {redirect_pc[PCW-1:1], 1'b0};
      drop_low_nxt = redirect_pc[1];
    end else begin
      // Issue only if the queue can absorb everything already requested
      issue  = (4'(cnt) + (inflight ? 4'd2 : 4'd0)) <= 4'd4;
      n_push = inflight ? (drop_low ? 2'd1 : 2'd2) : 2'd0;
      n_pop  = xfer ? (h0_rvc ? 2'd1 : 2'd2) : 2'd0;

      q_sh = q >> {n_pop, 4'b0000};
      base = 3'(cnt - 3'(n_pop));
      q_nxt = q_sh;
      for (int i = 0; i < QD; i++) begin
        if (n_push == 2'd2 && 3'(i) == base)             q_nxt[i] = imem_dout[15:0];
        if (n_push == 2'd2 && 3'(i) == 3'(base + 3'd1))  q_nxt[i] = imem_dout[31:16];
        if (n_push == 2'd1 && 3'(i) == base)             q_nxt[i] = imem_dout[31:16];
      end

      cnt_sum      = 4'(cnt) + 4'(n_push) - 4'(n_pop);
      cnt_nxt      = 3'(cnt_sum);
      fwa_nxt      = issue ? ADDR_WIDTH'(fwa + 1'b1) : fwa;
      pc_nxt       = xfer ? PCW'(pc + (h0_rvc ? PCW'(2) : PCW'(4))) : pc;
      inflight_nxt = issue;
      if (inflight) drop_low_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q        <= '0;
      cnt      <= 3'd0;
      fwa      <= RST_PC[PCW-1:2];
      pc       <= {RST_PC[PCW-1:1], 1'b0};
      inflight <= 1'b0;
      drop_low <= RST_PC[1];
    end else begin
      assert (cnt_sum <= 4'(QD));
      q        <= q_nxt;
      cnt      <= cnt_nxt;
      fwa      <= fwa_nxt;
      pc       <= pc_nxt;
      inflight <= inflight_nxt;
      drop_low <= drop_low_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_align.sv
// Directed bench for ifetch_align: aligned, compressed, straddling, stalled,
// redirected and reset-interrupted instruction streams.
module tb_ifetch_align;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dout;
  logic          redirect_valid;
  logic [AW+1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [AW+1:0] instr_pc;
  logic          instr_is_rvc;

  logic [31:0] ram [1 << AW];
  int nchecks = 0;
  int nerrors = 0;

  ifetch_align #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_is_rvc(instr_is_rvc)
  );

  always #5 clk = ~clk;

  // Synchronous 1-cycle-latency instruction memory
  always_ff @(posedge clk) imem_dout <= ram[imem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic rvc);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
    if (v) begin
      chk({tag, ".instr"}, instr, ins);
      chk({tag, ".pc"}, 32'(instr_pc), pc);
      chk({tag, ".rvc"}, 32'(instr_is_rvc), 32'(rvc));
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
  endtask

  // Leaves the bench at cycle 0 (first cycle with rst_n=1)
  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = rdy;
    step();
    rst_n = 1'b1;
    #1;
    chk_out("rst", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst.addr", 32'(imem_addr), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    clear_ram();
    step();

    // Aligned 32-bit stream
    ram[0] = 32'h00000013; ram[1] = 32'h00100093; ram[2] = 32'h00200113;
    do_reset(1'b1);
    step(); chk_out("al.c1", 1'b0, 32'h0, 32'h0, 1'b0);
    step(); chk_out("al.c2", 1'b1, 32'h00000013, 32'h000, 1'b0);
    step(); chk_out("al.c3", 1'b1, 32'h00100093, 32'h004, 1'b0);
    step(); chk_out("al.c4", 1'b1, 32'h00200113, 32'h008, 1'b0);

    // Compressed pair
    clear_ram();
    ram[0] = 32'h45014501;
    do_reset(1'b1);
    step(); step(); chk_out("rvc.c2", 1'b1, 32'h00004501, 32'h000, 1'b1);
    step(); chk_out("rvc.c3", 1'b1, 32'h00004501, 32'h002, 1'b1);

    // Word-straddling 32-bit instruction
    clear_ram();
    ram[0] = 32'h00134501; ram[1] = 32'h45010000;
    do_reset(1'b1);
    step(); step(); chk_out("str.c2", 1'b1, 32'h00004501, 32'h000, 1'b1);
    step(); chk_out("str.c3", 1'b1, 32'h00000013, 32'h002, 1'b0);
    step(); chk_out("str.c4", 1'b1, 32'h00004501, 32'h006, 1'b1);

    // Backpressure: 10 stalled cycles, then drain with no loss or duplication
    clear_ram();
    for (int i = 0; i < 16; i++) ram[i] = (32'(i) << 20) | 32'h13;
    do_reset(1'b0);
    step(); step();
    for (int k = 0; k < 10; k++) begin
      chk_out("bp.stall", 1'b1, ram[0], 32'h000, 1'b0);
      step();
    end
    instr_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk_out("bp.drain", 1'b1, ram[k], 32'(4 * k), 1'b0);
      step();
    end

    // Redirect to halfword-odd RVC target with a response in flight
    clear_ram();
    ram[0] = 32'h00000013; ram[1] = 32'h00100093;
    ram[2] = 32'h45010000; ram[3] = 32'h00300193;
    do_reset(1'b1);
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 11'h00A;
    #1; chk_out("rd.t", 1'b0, 32'h0, 32'h0, 1'b0);
    step(); redirect_valid = 1'b0;
    #1; chk_out("rd.t1", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rd.t1.addr", 32'(imem_addr), 32'h2);
    step(); chk_out("rd.t2", 1'b0, 32'h0, 32'h0, 1'b0);
    step(); chk_out("rd.t3", 1'b1, 32'h00004501, 32'h00A, 1'b1);
    step(); chk_out("rd.t4", 1'b1, 32'h00300193, 32'h00C, 1'b0);

    // Redirect to halfword-odd 32-bit target: one extra cycle
    clear_ram();
    ram[0] = 32'h00000013; ram[1] = 32'h00930000; ram[2] = 32'h00000010;
    do_reset(1'b1);
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 11'h006;
    step(); redirect_valid = 1'b0;
    step(); step();
    #1; chk_out("rd32.t3", 1'b0, 32'h0, 32'h0, 1'b0);
    step(); chk_out("rd32.t4", 1'b1, 32'h00100093, 32'h006, 1'b0);

    // Mid-stream reset, asserted together with a redirect
    clear_ram();
    ram[0] = 32'h00000013; ram[1] = 32'h00100093;
    do_reset(1'b1);
    step(); step(); step();
    chk_out("mr.pre", 1'b1, 32'h00100093, 32'h004, 1'b0);
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 11'h010;
    step(); rst_n = 1'b1; redirect_valid = 1'b0;
    #1; chk_out("mr.c0", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("mr.c0.addr", 32'(imem_addr), 32'h0);
    step(); chk_out("mr.c1", 1'b0, 32'h0, 32'h0, 1'b0);
    step(); chk_out("mr.c2", 1'b1, 32'h00000013, 32'h000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
